// File: rtl/csr_access_ctrl.sv
// CSR read-modify-write sequencer between execute and the CSR file; perf counters behind CSR_ACCESS_CTRL_PERF_EN.
// Latency: accept N, csr_rd_en N+1, csr_we N+2, resp_valid N+3.
// Backpressure: req_ready only in IDLE; response held in RESP until resp_ready.
module csr_access_ctrl #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [CSR_ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  input  logic                  req_src_zero,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_illegal,
  output logic                  stall,
  input  logic                  flush,
  output logic                  csr_rd_en,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  input  logic [XLEN-1:0]       csr_rd_data,
  output logic                  csr_we,
  output logic [XLEN-1:0]       csr_wdata,
  output logic [31:0]           perf_ops,
  output logic [15:0]           perf_illegal
);

  localparam logic [1:0] OP_NA = 2'b00;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, MODIFY, RESP} state_t;

  state_t                  state;
  logic [1:0]              op_q;
  logic [CSR_ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]         wdata_q;
  logic [XLEN-1:0]         rdata_q;
  logic                    src_zero_q;
  logic                    illegal_q;
  logic                    do_write;
  logic                    is_illegal;
  logic [XLEN-1:0]         new_val;

  // Set/clear with a zero source is a pure read, so it never counts as a write.
  always_comb begin
    do_write   = (op_q == OP_RW) || !src_zero_q;
    is_illegal = do_write && (addr_q[CSR_ADDR_W-1 -: 2] == 2'b11);
    case (op_q)
      OP_RW:   new_val = wdata_q;
      OP_RS:   new_val = csr_rd_data | wdata_q;
      default: new_val = csr_rd_data & ~wdata_q;
    endcase
  end

  // Write strobe decodes straight off the state flop so reset kills it at once.
  assign csr_we       = (state == MODIFY) && do_write && !is_illegal;
  assign csr_wdata    = csr_we ? new_val : '0;
  assign csr_addr     = addr_q;
  assign resp_rdata   = rdata_q;
  assign resp_illegal = illegal_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      op_q       <= OP_NA;
      addr_q     <= '0;
      wdata_q    <= '0;
      src_zero_q <= 1'b0;
      rdata_q    <= '0;
      illegal_q  <= 1'b0;
      req_ready  <= 1'b1;
      stall      <= 1'b0;
      csr_rd_en  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready && (req_op != OP_NA)) begin
            op_q       <= req_op;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            src_zero_q <= req_src_zero;
            state      <= READ;
            req_ready  <= 1'b0;
            stall      <= 1'b1;
            csr_rd_en  <= 1'b1;
          end
        end
        READ: begin
          csr_rd_en <= 1'b0;
          if (flush) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            stall     <= 1'b0;
          end else begin
            state <= MODIFY;
          end
        end
        MODIFY: begin
          rdata_q    <= csr_rd_data;
          illegal_q  <= is_illegal;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            stall      <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CSR_ACCESS_CTRL_PERF_EN
  logic [31:0] ops_q;
  logic [15:0] ill_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ops_q <= '0;
      ill_q <= '0;
    end else if (resp_valid && resp_ready) begin
      ops_q <= ops_q + 32'd1;
      if (illegal_q && (ill_q != 16'hFFFF)) ill_q <= ill_q + 16'd1;
    end
  end

  assign perf_ops     = ops_q;
  assign perf_illegal = ill_q;
`else
  assign perf_ops     = '0;
  assign perf_illegal = '0;
`endif

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: directed plus randomized CSR ops against a CSR-array reference model.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_src_zero = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_illegal;
  logic        stall;
  logic        flush = 1'b0;
  logic        csr_rd_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_rd_data = '0;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] perf_ops;
  logic [15:0] perf_illegal;

  csr_access_ctrl #(.XLEN(32), .CSR_ADDR_W(12)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_src_zero(req_src_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_illegal(resp_illegal), .stall(stall), .flush(flush),
    .csr_rd_en(csr_rd_en), .csr_addr(csr_addr), .csr_rd_data(csr_rd_data),
    .csr_we(csr_we), .csr_wdata(csr_wdata),
    .perf_ops(perf_ops), .perf_illegal(perf_illegal)
  );

  always #5 clk = ~clk;

  // CSR file environment: one-cycle read latency, writes land at the clock edge.
  logic [31:0] mem [0:4095] = '{default: 32'h0};
  int          we_cnt = 0;
  always @(posedge clk) begin
    if (csr_rd_en) csr_rd_data <= mem[csr_addr];
    if (csr_we) begin
      mem[csr_addr] <= csr_wdata;
      we_cnt        <= we_cnt + 1;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:4095] = '{default: 32'h0};
  int          ref_ops = 0;
  int          ref_ill = 0;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] addr_tbl [8] = '{12'h340, 12'h300, 12'hC00, 12'hC01, 12'h7FF, 12'hBFF, 12'hF14, 12'h001};

  // One CSR op driven from the first cycle in IDLE. flush_at: 0 none, 1 READ, 2 MODIFY.
  task automatic run_op(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                        input logic sz, input int flush_at, input int hold);
    logic [31:0] old_v, new_v, exp_ops;
    logic [15:0] exp_ill;
    logic dw, ill, exp_we;
    int we0;
    old_v  = ref_mem[addr];
    dw     = (op == 2'b01) || !sz;
    new_v  = (op == 2'b01) ? wd : (op == 2'b10) ? (old_v | wd) : (old_v & ~wd);
    ill    = dw && (addr >= 12'hC00);
    exp_we = dw && !ill && (flush_at != 1);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", req_ready); end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_src_zero = sz;
    we0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_addr = 12'($urandom); req_wdata = $urandom;
    checks++;
    if ({csr_rd_en, stall, req_ready, csr_we} !== 4'b1100 || csr_addr !== addr) begin
      errors++; $display("FAIL read_phase rd_en/stall/ready/we=%b addr=%h want 1100 addr=%h",
                         {csr_rd_en, stall, req_ready, csr_we}, csr_addr, addr);
    end
    if (flush_at == 1) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++;
      if ({req_ready, stall, resp_valid, csr_rd_en} !== 4'b1000) begin
        errors++; $display("FAIL flush_read ready/stall/rv/rd_en=%b want 1000", {req_ready, stall, resp_valid, csr_rd_en});
      end
      @(posedge clk); #1;
      checks++;
      if (we_cnt !== we0 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL flush_read_nowrite writes=%0d rv=%b want 0 0", we_cnt - we0, resp_valid);
      end
      return;
    end
    @(posedge clk); #1;
    if (flush_at == 2) flush = 1'b1;
    checks++;
    if (csr_we !== exp_we || stall !== 1'b1) begin
      errors++; $display("FAIL modify_we we=%b stall=%b want %b 1", csr_we, stall, exp_we);
    end
    if (exp_we) begin
      checks++;
      if (csr_wdata !== new_v) begin errors++; $display("FAIL modify_wdata got %h want %h", csr_wdata, new_v); end
    end
    @(posedge clk); #1;
    flush = 1'b0;
    if (exp_we) ref_mem[addr] = new_v;
    checks++;
    if ({resp_valid, stall, req_ready} !== 3'b110 || resp_rdata !== old_v || resp_illegal !== ill
        || we_cnt !== we0 + (exp_we ? 1 : 0)) begin
      errors++; $display("FAIL resp rv/stall/ready=%b rdata=%h ill=%b writes=%0d want 110 %h %b %0d",
                         {resp_valid, stall, req_ready}, resp_rdata, resp_illegal, we_cnt - we0, old_v, ill, exp_we);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({resp_valid, stall, req_ready} !== 3'b110 || resp_rdata !== old_v || resp_illegal !== ill) begin
        errors++; $display("FAIL resp_hold cyc%0d rv/stall/ready=%b rdata=%h ill=%b want 110 %h %b",
                           i, {resp_valid, stall, req_ready}, resp_rdata, resp_illegal, old_v, ill);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    ref_ops++;
    if (ill && ref_ill < 16'hFFFF) ref_ill++;
`ifdef CSR_ACCESS_CTRL_PERF_EN
    exp_ops = 32'(ref_ops); exp_ill = 16'(ref_ill);
`else
    exp_ops = '0; exp_ill = '0;
`endif
    checks++;
    if ({resp_valid, req_ready, stall} !== 3'b010 || mem[addr] !== ref_mem[addr]) begin
      errors++; $display("FAIL post_handshake rv/ready/stall=%b csr=%h want 010 %h",
                         {resp_valid, req_ready, stall}, mem[addr], ref_mem[addr]);
    end
    checks++;
    if (perf_ops !== exp_ops || perf_illegal !== exp_ill) begin
      errors++; $display("FAIL perf ops=%0d ill=%0d want %0d %0d", perf_ops, perf_illegal, exp_ops, exp_ill);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, stall, csr_rd_en, csr_we, resp_illegal} !== 6'b100000
        || csr_addr !== '0 || csr_wdata !== '0 || resp_rdata !== '0 || perf_ops !== '0 || perf_illegal !== '0) begin
      errors++; $display("FAIL reset_outputs ready/rv/stall/rd/we/ill=%b addr=%h wd=%h rd=%h want 100000 zeros",
                         {req_ready, resp_valid, stall, csr_rd_en, csr_we, resp_illegal}, csr_addr, csr_wdata, resp_rdata);
    end
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_release ready=%b stall=%b want 1 0", req_ready, stall);
    end
  endtask

  task automatic test_rs_basic();
    run_op(2'b01, 12'h340, 32'h0000_00F0, 1'b0, 0, 0);
    run_op(2'b10, 12'h340, 32'h0000_000F, 1'b0, 0, 0);
  endtask

  task automatic test_rc_rw();
    run_op(2'b01, 12'h300, 32'hFFFF_FFFF, 1'b0, 0, 0);
    run_op(2'b11, 12'h300, 32'h0000_0008, 1'b0, 0, 0);
    run_op(2'b01, 12'h300, 32'h0000_1234, 1'b0, 0, 1);
  endtask

  task automatic test_readonly();
    run_op(2'b10, 12'hC00, 32'h0000_0055, 1'b1, 0, 0);
    run_op(2'b10, 12'hC00, 32'h0000_0055, 1'b0, 0, 0);
    run_op(2'b11, 12'hFFF, 32'h0000_0001, 1'b0, 0, 0);
  endtask

  task automatic test_flush();
    run_op(2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0, 1, 0);
    run_op(2'b01, 12'h340, 32'hCAFE_F00D, 1'b0, 2, 0);
  endtask

  task automatic test_backpressure();
    run_op(2'b10, 12'h7FF, 32'h0000_0100, 1'b0, 0, 5);
  endtask

  task automatic test_na();
    int we0;
    we0 = we_cnt;
    req_valid = 1'b1; req_op = 2'b00; req_addr = 12'h340;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, stall, csr_rd_en, resp_valid} !== 4'b1000 || we_cnt !== we0) begin
      errors++; $display("FAIL na_op ready/stall/rd/rv=%b writes=%0d want 1000 0",
                         {req_ready, stall, csr_rd_en, resp_valid}, we_cnt - we0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      run_op(2'($urandom_range(1, 3)), addr_tbl[$urandom_range(0, 7)], $urandom,
             ($urandom_range(0, 3) == 0), (r == 0) ? 1 : (r == 1) ? 2 : 0, $urandom_range(0, 3));
    end
  endtask

  task automatic test_midop_reset();
    req_valid = 1'b1; req_op = 2'b01; req_addr = 12'h340; req_wdata = 32'h5A5A_5A5A; req_src_zero = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (csr_we !== 1'b1) begin errors++; $display("FAIL midreset_pre we=%b want 1", csr_we); end
    resetn = 1'b0;
    #1;
    checks++;
    if ({csr_we, stall, req_ready, csr_rd_en, resp_valid} !== 5'b00100) begin
      errors++; $display("FAIL midreset we/stall/ready/rd/rv=%b want 00100", {csr_we, stall, req_ready, csr_rd_en, resp_valid});
    end
    ref_ops = 0; ref_ill = 0;
    #3 resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem[12'h340] !== ref_mem[12'h340] || perf_ops !== '0 || perf_illegal !== '0) begin
      errors++; $display("FAIL midreset_post csr=%h ops=%0d ill=%0d want %h 0 0",
                         mem[12'h340], perf_ops, perf_illegal, ref_mem[12'h340]);
    end
  endtask

  task automatic test_perf();
    run_op(2'b01, 12'h340, 32'h0000_0001, 1'b0, 0, 0);
    run_op(2'b10, 12'h300, 32'h0000_0002, 1'b0, 0, 0);
    run_op(2'b11, 12'h7FF, 32'h0000_0004, 1'b0, 0, 0);
    run_op(2'b01, 12'hC00, 32'h0000_0008, 1'b0, 0, 0);
    #2 resetn = 1'b0;
    #2 resetn = 1'b1;
    ref_ops = 0; ref_ill = 0;
    @(posedge clk); #1;
    checks++;
    if (perf_ops !== '0 || perf_illegal !== '0) begin
      errors++; $display("FAIL perf_reset ops=%0d ill=%0d want 0 0", perf_ops, perf_illegal);
    end
  endtask

  initial begin
    test_reset();
    test_rs_basic();
    test_rc_rw();
    test_readonly();
    test_flush();
    test_backpressure();
    test_na();
    test_random();
    test_midop_reset();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
